// File: rtl/load_pend_ctrl.sv
// load_pend_ctrl: outstanding-load tracker for a variable-latency data memory.
// Queues {rd, sx_size} per issued load and returns them with the in-order
// memory response. Stalls issue on a full queue, a load-use RAW hazard or a
// write-back port conflict. A watchdog FSM flags a lost response.
// Optional build macro: LOAD_FWD_EN adds a bypass of the returning load data
// (fwd_rs1 / fwd_rs2) and lifts the RAW stall for a popping head entry.
module load_pend_ctrl #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned SX_W    = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic                       issue_load,
  input  logic                       issue_we,
  input  logic [RA_W-1:0]            issue_rd,
  input  logic [SX_W-1:0]            issue_sx,
  input  logic [RA_W-1:0]            rs1,
  input  logic [RA_W-1:0]            rs2,
  input  logic                       use_rs1,
  input  logic                       use_rs2,
  input  logic                       mem_rvalid,
  input  logic                       err_clr,
  output logic                       stall,
  output logic                       delayed_load,
  output logic [RA_W-1:0]            delayed_rd,
  output logic [SX_W-1:0]            delayed_sx,
  output logic [$clog2(DEPTH):0]     pend_cnt,
  output logic                       err
`ifdef LOAD_FWD_EN
  ,
  output logic                       fwd_rs1,
  output logic                       fwd_rs2
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, PEND, ERR} state_t;

  state_t            state, state_nxt;
  logic [RA_W-1:0]   q_rd [DEPTH];
  logic [SX_W-1:0]   q_sx [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [AW-1:0]     head, tail;
  logic [TW-1:0]     wd, wd_nxt;
  logic              push, pop, flush;
  logic [DEPTH-1:0]  m1, m2, head_oh;
  logic              haz1, haz2, full;

  // Source-register match against every occupied queue slot
  always_comb begin
    m1      = '0;
    m2      = '0;
    head_oh = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m1[i] = vld[i] && (q_rd[i] == rs1);
      m2[i] = vld[i] && (q_rd[i] == rs2);
    end
    head_oh[head] = 1'b1;
  end

  // Pop, write-back outputs, hazards and stall
  always_comb begin
    full         = (pend_cnt == CW'(DEPTH));
    pop          = mem_rvalid && (pend_cnt != '0) && (state != ERR);
    delayed_load = pop && (q_rd[head] != '0);
    delayed_rd   = pop ? q_rd[head] : '0;
    delayed_sx   = pop ? q_sx[head] : '0;
`ifdef LOAD_FWD_EN
    // a head match that returns this cycle is served by the bypass instead
    haz1    = use_rs1 && (rs1 != '0) && ((m1 & ~(pop ? head_oh : '0)) != '0);
    haz2    = use_rs2 && (rs2 != '0) && ((m2 & ~(pop ? head_oh : '0)) != '0);
    fwd_rs1 = issue_valid && use_rs1 && (rs1 != '0) && pop && (m1 == head_oh);
    fwd_rs2 = issue_valid && use_rs2 && (rs2 != '0) && pop && (m2 == head_oh);
`else
    haz1    = use_rs1 && (rs1 != '0) && (m1 != '0);
    haz2    = use_rs2 && (rs2 != '0) && (m2 != '0);
`endif
    stall = issue_valid && ((issue_load && full) || haz1 || haz2 ||
                            (issue_we && delayed_load) || (state == ERR));
    push  = issue_valid && issue_load && !stall;
    err   = (state == ERR);
  end

  // Watchdog FSM next-state
  always_comb begin
    state_nxt = state;
    wd_nxt    = wd;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        wd_nxt = '0;
        if (push) state_nxt = PEND;
      end
      PEND: begin
        if (pop) begin
          wd_nxt = '0;
          if ((pend_cnt == CW'(1)) && !push) state_nxt = IDLE;
        end else if (wd == TW'(TIMEOUT - 1)) begin
          wd_nxt    = '0;
          flush     = 1'b1;
          state_nxt = ERR;
        end else begin
          wd_nxt = wd + TW'(1);
        end
      end
      ERR: begin
        wd_nxt = '0;
        if (err_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, watchdog counter, queue pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wd       <= '0;
      head     <= '0;
      tail     <= '0;
      vld      <= '0;
      pend_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_rd[i] <= '0;
        q_sx[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      wd    <= wd_nxt;
      if (flush) begin
        head     <= '0;
        tail     <= '0;
        vld      <= '0;
        pend_cnt <= '0;
      end else begin
        // push never targets the head slot: full stalls even when a pop coincides
        if (push) begin
          q_rd[tail] <= issue_rd;
          q_sx[tail] <= issue_sx;
          vld[tail]  <= 1'b1;
          tail       <= tail + AW'(1);
        end
        if (pop) begin
          vld[head] <= 1'b0;
          head      <= head + AW'(1);
        end
        case ({push, pop})
          2'b10:   pend_cnt <= pend_cnt + CW'(1);
          2'b01:   pend_cnt <= pend_cnt - CW'(1);
          default: pend_cnt <= pend_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_pend_ctrl.sv
// Self-checking bench for load_pend_ctrl (DEPTH=2, TIMEOUT=16).
// Issued loads are pushed to a scoreboard queue; each memory response pops it.
module tb_load_pend_ctrl;

  logic       clk, rst;
  logic       issue_valid, issue_load, issue_we;
  logic [4:0] issue_rd, rs1, rs2;
  logic [2:0] issue_sx;
  logic       use_rs1, use_rs2, mem_rvalid, err_clr;
  logic       stall, delayed_load, err;
  logic [4:0] delayed_rd;
  logic [2:0] delayed_sx;
  logic [1:0] pend_cnt;
`ifdef LOAD_FWD_EN
  logic       fwd_rs1, fwd_rs2;
`endif

  typedef struct {
    logic [4:0] rd;
    logic [2:0] sx;
  } ent_t;

  ent_t sbq[$];
  ent_t e;
  int   total = 0;
  int   bad   = 0;

  load_pend_ctrl #(.DEPTH(2), .RA_W(5), .SX_W(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_load(issue_load), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_sx(issue_sx),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .mem_rvalid(mem_rvalid), .err_clr(err_clr),
    .stall(stall), .delayed_load(delayed_load),
    .delayed_rd(delayed_rd), .delayed_sx(delayed_sx),
    .pend_cnt(pend_cnt), .err(err)
`ifdef LOAD_FWD_EN
    , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, got running want done");
    $fatal(1);
  end

  task automatic idle_in();
    issue_valid = 0; issue_load = 0; issue_we = 0; issue_rd = 0; issue_sx = 0;
    rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0; mem_rvalid = 0; err_clr = 0;
  endtask

  task automatic issue_ld(input logic [4:0] rd, input logic [2:0] sx);
    idle_in();
    issue_valid = 1; issue_load = 1; issue_rd = rd; issue_sx = sx;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_in();
    issue_valid = 1; issue_load = 1; issue_rd = 3; use_rs1 = 1; rs1 = 3; mem_rvalid = 1;
    #2;
    total++; if (pend_cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", pend_cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", err); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0b want 0", stall); end
    total++; if (delayed_load !== 1'b0 || delayed_rd !== 5'd0 || delayed_sx !== 3'd0) begin
      bad++; $display("FAIL rst_wb: got %0b/%0d/%0d want 0/0/0", delayed_load, delayed_rd, delayed_sx);
    end
    @(negedge clk); idle_in();
    @(negedge clk); rst = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    issue_ld(5, 3'b100); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL basic_issue: stall got %0b want 0", stall); end
    if (!stall) sbq.push_back('{rd: 5'd5, sx: 3'b100});
    @(negedge clk); idle_in(); #1;
    total++; if (pend_cnt !== 2'd1) begin bad++; $display("FAIL basic_cnt1: got %0d want 1", pend_cnt); end
    total++; if (delayed_load !== 1'b0) begin bad++; $display("FAIL basic_nowb: got %0b want 0", delayed_load); end
    @(negedge clk); @(negedge clk);
    mem_rvalid = 1; #1;
    e = sbq.pop_front();
    total++; if (delayed_load !== (e.rd != 0) || delayed_rd !== e.rd || delayed_sx !== e.sx) begin
      bad++; $display("FAIL basic_wb: got %0b/%0d/%0d want %0b/%0d/%0d", delayed_load, delayed_rd, delayed_sx, e.rd != 0, e.rd, e.sx);
    end
    @(negedge clk); idle_in(); #1;
    total++; if (pend_cnt !== 2'd0 || delayed_load !== 1'b0) begin
      bad++; $display("FAIL basic_cnt0: got cnt=%0d dl=%0b want 0/0", pend_cnt, delayed_load);
    end
    @(negedge clk);
  endtask

  task automatic test_full();
    issue_ld(1, 0); #1;
    if (!stall) sbq.push_back('{rd: 5'd1, sx: 3'd0});
    @(negedge clk); issue_ld(2, 1); #1;
    total++; if (stall !== 1'b0 || pend_cnt !== 2'd1) begin
      bad++; $display("FAIL full_second: got stall=%0b cnt=%0d want 0/1", stall, pend_cnt);
    end
    if (!stall) sbq.push_back('{rd: 5'd2, sx: 3'd1});
    @(negedge clk); issue_ld(3, 2); #1;
    total++; if (stall !== 1'b1 || pend_cnt !== 2'd2) begin
      bad++; $display("FAIL full_third: got stall=%0b cnt=%0d want 1/2", stall, pend_cnt);
    end
    @(negedge clk); issue_ld(3, 2); mem_rvalid = 1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_pop_stall: got %0b want 1", stall); end
    e = sbq.pop_front();
    total++; if (delayed_load !== (e.rd != 0) || delayed_rd !== e.rd || delayed_sx !== e.sx) begin
      bad++; $display("FAIL full_wb1: got %0b/%0d/%0d want %0b/%0d/%0d", delayed_load, delayed_rd, delayed_sx, e.rd != 0, e.rd, e.sx);
    end
    @(negedge clk); issue_ld(3, 2); #1;
    total++; if (stall !== 1'b0 || pend_cnt !== 2'd1) begin
      bad++; $display("FAIL full_push3: got stall=%0b cnt=%0d want 0/1", stall, pend_cnt);
    end
    if (!stall) sbq.push_back('{rd: 5'd3, sx: 3'd2});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle_in(); mem_rvalid = 1; #1;
      e = sbq.pop_front();
      total++; if (delayed_load !== (e.rd != 0) || delayed_rd !== e.rd || delayed_sx !== e.sx) begin
        bad++; $display("FAIL full_drain%0d: got %0b/%0d/%0d want %0b/%0d/%0d", k, delayed_load, delayed_rd, delayed_sx, e.rd != 0, e.rd, e.sx);
      end
    end
    @(negedge clk); idle_in(); #1;
    total++; if (pend_cnt !== 2'd0) begin bad++; $display("FAIL full_empty: got %0d want 0", pend_cnt); end
    @(negedge clk);
  endtask

  task automatic test_raw();
    issue_ld(7, 3'b010); #1;
    if (!stall) sbq.push_back('{rd: 5'd7, sx: 3'b010});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle_in(); issue_valid = 1; use_rs2 = 1; rs2 = 7; use_rs1 = 1; rs1 = 0; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_wait%0d: got %0b want 1", k, stall); end
    end
    mem_rvalid = 1; #1;
`ifdef LOAD_FWD_EN
    total++; if (stall !== 1'b0 || fwd_rs2 !== 1'b1 || fwd_rs1 !== 1'b0) begin
      bad++; $display("FAIL raw_fwd: got stall=%0b f2=%0b f1=%0b want 0/1/0", stall, fwd_rs2, fwd_rs1);
    end
`else
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_ret: got %0b want 1", stall); end
`endif
    e = sbq.pop_front();
    total++; if (delayed_load !== (e.rd != 0) || delayed_rd !== e.rd || delayed_sx !== e.sx) begin
      bad++; $display("FAIL raw_wb: got %0b/%0d/%0d want %0b/%0d/%0d", delayed_load, delayed_rd, delayed_sx, e.rd != 0, e.rd, e.sx);
    end
    @(negedge clk); mem_rvalid = 0; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_clear: got %0b want 0", stall); end
    // load to x0 still queued; reading x0 never stalls
    @(negedge clk); issue_ld(0, 3'b011); #1;
    if (!stall) sbq.push_back('{rd: 5'd0, sx: 3'b011});
    @(negedge clk); idle_in(); issue_valid = 1; use_rs1 = 1; use_rs2 = 1; #1;
    total++; if (stall !== 1'b0 || pend_cnt !== 2'd1) begin
      bad++; $display("FAIL x0_read: got stall=%0b cnt=%0d want 0/1", stall, pend_cnt);
    end
    @(negedge clk); idle_in(); mem_rvalid = 1; #1;
    e = sbq.pop_front();
    total++; if (delayed_load !== (e.rd != 0) || delayed_rd !== e.rd || delayed_sx !== e.sx) begin
      bad++; $display("FAIL x0_wb: got %0b/%0d/%0d want %0b/%0d/%0d", delayed_load, delayed_rd, delayed_sx, e.rd != 0, e.rd, e.sx);
    end
    @(negedge clk); idle_in(); #1;
    total++; if (pend_cnt !== 2'd0) begin bad++; $display("FAIL x0_cnt: got %0d want 0", pend_cnt); end
    @(negedge clk);
  endtask

  task automatic test_port_conflict();
    issue_ld(9, 3'b001); #1;
    if (!stall) sbq.push_back('{rd: 5'd9, sx: 3'b001});
    @(negedge clk); idle_in();
    @(negedge clk); issue_valid = 1; issue_we = 1; mem_rvalid = 1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL port_stall: got %0b want 1", stall); end
    e = sbq.pop_front();
    total++; if (delayed_load !== (e.rd != 0) || delayed_rd !== e.rd || delayed_sx !== e.sx) begin
      bad++; $display("FAIL port_wb: got %0b/%0d/%0d want %0b/%0d/%0d", delayed_load, delayed_rd, delayed_sx, e.rd != 0, e.rd, e.sx);
    end
    @(negedge clk); mem_rvalid = 0; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL port_release: got %0b want 0", stall); end
    @(negedge clk); idle_in();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    issue_ld(4, 3'b100); #1;
    if (!stall) sbq.push_back('{rd: 5'd4, sx: 3'b100});
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); idle_in(); err_clr = (k == 3); // err_clr ignored while pending
    end
    #1;
    total++; if (err !== 1'b0 || pend_cnt !== 2'd1) begin
      bad++; $display("FAIL tmo_early: got err=%0b cnt=%0d want 0/1", err, pend_cnt);
    end
    @(negedge clk); idle_in(); issue_valid = 1; issue_load = 1; issue_rd = 6; #1;
    sbq.delete();
    total++; if (err !== 1'b1 || pend_cnt !== 2'd0) begin
      bad++; $display("FAIL tmo_err: got err=%0b cnt=%0d want 1/0", err, pend_cnt);
    end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL tmo_stall_ld: got %0b want 1", stall); end
    @(negedge clk); idle_in(); issue_valid = 1; mem_rvalid = 1; #1;
    total++; if (stall !== 1'b1 || delayed_load !== 1'b0) begin
      bad++; $display("FAIL tmo_err_issue: got stall=%0b dl=%0b want 1/0", stall, delayed_load);
    end
    @(negedge clk); idle_in(); err_clr = 1; #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %0b want 1", err); end
    @(negedge clk); idle_in(); mem_rvalid = 1; issue_valid = 1; issue_we = 1; #1;
    total++; if (err !== 1'b0 || stall !== 1'b0 || delayed_load !== 1'b0 || pend_cnt !== 2'd0) begin
      bad++; $display("FAIL tmo_clear: got err=%0b stall=%0b dl=%0b cnt=%0d want 0/0/0/0", err, stall, delayed_load, pend_cnt);
    end
    @(negedge clk); idle_in(); #1;
    total++; if (pend_cnt !== 2'd0 || err !== 1'b0) begin
      bad++; $display("FAIL tmo_late: got cnt=%0d err=%0b want 0/0", pend_cnt, err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_raw();
    test_port_conflict();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
